alu_flag_branch_unit: RTL and testbench
=======================================

# alu_flag_branch_unit

Consumer side of the ALU's flag outputs in the KGP-miniRISC datapath. Latches the ALU's carry/zero/sign into an architectural flag register and evaluates miniRISC conditional branches against it. Drives a PC-redirect handshake, a link-register write for `bl`, and a fixed-length pipeline flush after every taken branch. Sits between the ALU and the fetch/PC logic.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles `flush` stays high after a redirect is accepted. Legal range is 1..15.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `alu_carry`, `alu_zero`, `alu_sign`  in  1 each: ALU flag outputs for the current instruction.
- `flag_we`  in  1: load the three ALU flags into the flag register this cycle.
- `br_valid`  in  1: a branch request is presented.
- `br_ready`  out  1: unit can accept a branch. High only in IDLE.
- `br_op`  in  3: branch opcode.
- `br_target`  in  32: branch target address.
- `pc_plus4`  in  32: return address used by `bl`.
- `flags_q`  out  3: registered flags, ordered {carry, zero, sign}.
- `br_done`  out  1: one-cycle pulse when a request finishes with not-taken or illegal.
- `br_illegal`  out  1: one-cycle pulse that accompanies `br_done` for opcode 111.
- `redirect_valid`  out  1: a PC redirect is pending.
- `redirect_ready`  in  1: fetch accepts the redirect.
- `redirect_pc`  out  32: redirect address.
- `link_we`  out  1: one-cycle link-register write strobe.
- `link_data`  out  32: value written to the link register.
- `flush`  out  1: invalidate the instructions younger than the branch.

## Operation
Opcode decode:
- 000 `b`: always taken.
- 001 `bltz`: taken if sign.
- 010 `bz`: taken if zero.
- 011 `bnz`: taken if !zero.
- 100 `bl`: always taken, and links.
- 101 `bcy`: taken if carry.
- 110 `bncy`: taken if !carry.
- 111: illegal, treated as not taken.

Flag register:
- Loads `{alu_carry, alu_zero, alu_sign}` on any edge where `flag_we`=1, in every state.
- Flags are never cleared except by reset.

States:
- IDLE:
  - `br_ready`=1.
  - On `br_valid`: capture `br_op`, `br_target` and `pc_plus4`, and register the decision.
  - Taken → REDIRECT. Not taken or illegal → DONE.
- DONE (1 cycle):
  - `br_done`=1, plus `br_illegal`=1 if the opcode was 111.
  - → IDLE.
- REDIRECT:
  - `redirect_valid`=1 and `redirect_pc`=captured target.
  - Holds until `redirect_ready`=1, then → FLUSH and loads the flush counter with `FLUSH_CYCLES`-1.
  - `link_we` pulses in the first REDIRECT cycle only, for `bl`, with `link_data`=captured `pc_plus4`.
- FLUSH:
  - `flush`=1.
  - Counter decrements each cycle; leaving at 0 → IDLE.
  - Exactly `FLUSH_CYCLES` flush cycles.

General rules:
- Outputs `redirect_pc` and `link_data` hold their last value when not strobed.
- `br_valid` is ignored outside IDLE. The requester must hold it until it sees `br_ready`, and must drop it after acceptance.

## Timing
Latencies, with acceptance at edge N:
- Not taken: `br_done` high in cycle N+1; `br_ready` high again in N+2.
- Taken: `redirect_valid` rises in N+1.
- Taken with `redirect_ready` already high: `flush` is high in N+2..N+1+`FLUSH_CYCLES`, and IDLE is reached one cycle later.
- `redirect_valid` stalls indefinitely while `redirect_ready`=0. `redirect_pc` is stable during the stall.

Reset (`rst_n` low, asynchronous):
- State IDLE and `flags_q`=000.
- `br_done`, `br_illegal`, `redirect_valid`, `link_we` and `flush` are 0.
- `redirect_pc` and `link_data` are 0.
- `br_ready`=1.
- Reset mid-REDIRECT or mid-FLUSH aborts immediately; no `link_we` is issued afterward.

Simultaneous `flag_we` and branch acceptance in one cycle: the flag source is set by the macro below. The flag register is updated either way.

## Configuration
`FLAG_BYPASS_EN`:
- Defined: a branch accepted in the same cycle as `flag_we`=1 evaluates against the incoming ALU flags, which are forwarded.
- Undefined: the branch evaluates against `flags_q` as it was before the edge, which is the old flags. The compiler/hazard logic must then insert one bubble.
- All other timing is identical in both builds.

## Test plan
- Reset, then `flag_we` with carry=1, zero=0, sign=1 → `flags_q`=101 next cycle; `br_ready`=1.
- With zero=1 in flags, `bz` to 0x0000_0040 → `redirect_valid` in N+1 with `redirect_pc`=0x40. Hold `redirect_ready`=0 for 3 cycles, then 1 → `flush` high exactly 2 cycles, then `br_ready`=1.
- `bl` with target 0x100 and `pc_plus4`=0x24 → `link_we` pulses once with `link_data`=0x24, and redirect goes to 0x100.
- Flags 000, `bcy`, then opcode 111 → `br_done` pulses each time, `br_illegal` only on the second, and no `redirect_valid`.
- Flags 000; in the same cycle `flag_we` (zero=1) and `bz` accepted → with `FLAG_BYPASS_EN`, taken; without it, `br_done` (not taken).
- `rst_n` asserted during FLUSH → all strobes drop to 0 at once, `flags_q`=000, and `br_ready`=1 after release.

Source files
------------

// File: rtl/alu_flag_branch_unit.sv
// rtl/alu_flag_branch_unit.sv - miniRISC flag register and conditional branch unit
//
// Latches ALU carry/zero/sign into an architectural flag register and resolves
// conditional branches against it, driving a PC-redirect handshake, a link
// write for bl, and a FLUSH_CYCLES-long flush after each accepted redirect.
//
// Parameter: FLUSH_CYCLES (1..15) - flush cycles after a redirect is accepted.
// Build option: define FLAG_BYPASS_EN to evaluate a branch accepted together
//               with flag_we against the incoming ALU flags instead of flags_q.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   alu_carry/zero/sign, flag_we   ALU flags and flag register load enable
//   br_valid/br_ready              branch request handshake
//   br_op, br_target, pc_plus4     branch opcode, target, return address
//   flags_q                        registered flags {carry, zero, sign}
//   br_done, br_illegal            not-taken / illegal completion pulses
//   redirect_valid/ready/pc        PC redirect handshake and address
//   link_we, link_data             link register write strobe and value
//   flush                          squash younger instructions
module alu_flag_branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_sign,
    input  logic        flag_we,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_op,
    input  logic [31:0] br_target,
    input  logic [31:0] pc_plus4,
    output logic [2:0]  flags_q,
    output logic        br_done,
    output logic        br_illegal,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        flush
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DONE     = 2'd1,
        S_REDIRECT = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    localparam logic [3:0] LP_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [2:0] LP_OP_BL      = 3'b100;
    localparam logic [2:0] LP_OP_ILLEGAL = 3'b111;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_flags;
    logic [2:0]  r_op;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_link_data;
    logic        r_first;
    logic [3:0]  r_cnt;
    logic [2:0]  w_eval_flags;
    logic        w_taken;
    logic        w_accept;

    assign w_accept = (r_state == S_IDLE) && br_valid;

`ifdef FLAG_BYPASS_EN
    // Forward the flags being written this cycle so back-to-back compare and
    // branch need no bubble.
    assign w_eval_flags = flag_we ? {alu_carry, alu_zero, alu_sign} : r_flags;
`else
    assign w_eval_flags = r_flags;
`endif

    // Flag bit order: [2]=carry, [1]=zero, [0]=sign.
    always_comb begin
        w_taken = 1'b0;
        case (br_op)
            3'b000:  w_taken = 1'b1;
            3'b001:  w_taken = w_eval_flags[0];
            3'b010:  w_taken = w_eval_flags[1];
            3'b011:  w_taken = !w_eval_flags[1];
            3'b100:  w_taken = 1'b1;
            3'b101:  w_taken = w_eval_flags[2];
            3'b110:  w_taken = !w_eval_flags[2];
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        br_ready       = 1'b0;
        br_done        = 1'b0;
        br_illegal     = 1'b0;
        redirect_valid = 1'b0;
        link_we        = 1'b0;
        flush          = 1'b0;
        case (r_state)
            S_IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    w_next = w_taken ? S_REDIRECT : S_DONE;
                end
            end
            S_DONE: begin
                br_done    = 1'b1;
                br_illegal = (r_op == LP_OP_ILLEGAL);
                w_next     = S_IDLE;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                // r_first limits the link write to one strobe even if fetch stalls.
                link_we        = r_first && (r_op == LP_OP_BL);
                if (redirect_ready) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags       <= 3'b000;
            r_op          <= 3'b000;
            r_redirect_pc <= 32'd0;
            r_link_data   <= 32'd0;
            r_first       <= 1'b0;
            r_cnt         <= 4'd0;
        end else begin
            if (flag_we) begin
                r_flags <= {alu_carry, alu_zero, alu_sign};
            end
            r_first <= w_accept && w_taken;
            if (w_accept) begin
                r_op <= br_op;
                // Redirect and link outputs only change when they are about to be used.
                if (w_taken) begin
                    r_redirect_pc <= br_target;
                    if (br_op == LP_OP_BL) begin
                        r_link_data <= pc_plus4;
                    end
                end
            end
            if ((r_state == S_REDIRECT) && redirect_ready) begin
                r_cnt <= LP_FLUSH_LOAD;
            end else if ((r_state == S_FLUSH) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign flags_q     = r_flags;
    assign redirect_pc = r_redirect_pc;
    assign link_data   = r_link_data;

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// tb/tb_alu_flag_branch_unit.sv - scoreboard bench for alu_flag_branch_unit
module tb_alu_flag_branch_unit;

    localparam int K_DONE  = 0;
    localparam int K_REDIR = 1;
    localparam int K_LINK  = 2;
    localparam int K_FLUSH = 3;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        alu_carry, alu_zero, alu_sign, flag_we;
    logic        br_valid, br_ready;
    logic [2:0]  br_op;
    logic [31:0] br_target, pc_plus4;
    logic [2:0]  flags_q;
    logic        br_done, br_illegal, redirect_valid, redirect_ready;
    logic [31:0] redirect_pc, link_data;
    logic        link_we, flush;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   flush_run = 0;

    alu_flag_branch_unit #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .flag_we(flag_we),
        .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op),
        .br_target(br_target), .pc_plus4(pc_plus4),
        .flags_q(flags_q),
        .br_done(br_done), .br_illegal(br_illegal),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc),
        .link_we(link_we), .link_data(link_data),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic check_pop(input int kind, input logic [31:0] act, input string name);
        exp_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s unexpected: got %h expected no event", name, act);
        end else begin
            e = q.pop_front();
            chk({name, "_kind"}, 32'(kind), 32'(e.kind));
            chk(name, act, e.data);
        end
    endtask

    // Monitor: compares every observable DUT event against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            flush_run = 0;
        end else begin
            if (link_we) check_pop(K_LINK, link_data, "link");
            if (redirect_valid && redirect_ready) check_pop(K_REDIR, redirect_pc, "redir");
            if (br_done) check_pop(K_DONE, {31'd0, br_illegal}, "done");
            if (flush) begin
                flush_run++;
            end else if (flush_run != 0) begin
                check_pop(K_FLUSH, 32'(flush_run), "flush_len");
                flush_run = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (br_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_flags(input logic c, input logic z, input logic s);
        wait_idle();
        alu_carry = c; alu_zero = z; alu_sign = s; flag_we = 1'b1;
        tick();
        flag_we = 1'b0;
    endtask

    // Returns in cycle N+1 where N is the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] tgt, input logic [31:0] pc4);
        wait_idle();
        br_op = op; br_target = tgt; pc_plus4 = pc4; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; alu_carry = 0; alu_zero = 0; alu_sign = 0; flag_we = 0;
        br_valid = 0; br_op = 0; br_target = 0; pc_plus4 = 0; redirect_ready = 0;
        #12;
        chk("rst_flags", {29'd0, flags_q}, 32'd0);
        chk("rst_ready", {31'd0, br_ready}, 32'd1);
        chk("rst_strobes", {27'd0, br_done, br_illegal, redirect_valid, link_we, flush}, 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_link", link_data, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        tick();

        // Flag load
        set_flags(1'b1, 1'b0, 1'b1);
        chk("flags_101", {29'd0, flags_q}, 32'h5);
        chk("ready_after_flags", {31'd0, br_ready}, 32'd1);

        // bz taken with stalled redirect
        set_flags(1'b0, 1'b1, 1'b0);
        push(K_REDIR, 32'h40); push(K_FLUSH, 32'd2);
        issue(3'b010, 32'h40, 32'h10);
        chk("bz_rv_n1", {31'd0, redirect_valid}, 32'd1);
        chk("bz_pc_n1", redirect_pc, 32'h40);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bz_stall_rv", {31'd0, redirect_valid}, 32'd1);
            chk("bz_stall_pc", redirect_pc, 32'h40);
        end
        tick();
        redirect_ready = 1'b1;
        tick();
        chk("bz_flush1", {31'd0, flush}, 32'd1);
        tick();
        chk("bz_flush2", {31'd0, flush}, 32'd1);
        tick();
        chk("bz_flush_end", {31'd0, flush}, 32'd0);
        chk("bz_ready_back", {31'd0, br_ready}, 32'd1);

        // bl with fetch ready
        push(K_LINK, 32'h24); push(K_REDIR, 32'h100); push(K_FLUSH, 32'd2);
        issue(3'b100, 32'h100, 32'h24);
        chk("bl_link_we", {31'd0, link_we}, 32'd1);
        chk("bl_link_data", link_data, 32'h24);
        tick();
        chk("bl_link_once", {31'd0, link_we}, 32'd0);
        chk("bl_flush_n2", {31'd0, flush}, 32'd1);

        // Not taken and illegal
        set_flags(1'b0, 1'b0, 1'b0);
        push(K_DONE, 32'd0);
        issue(3'b101, 32'h500, 32'h0);
        chk("bcy_done_n1", {31'd0, br_done}, 32'd1);
        chk("bcy_no_redir", {31'd0, redirect_valid}, 32'd0);
        tick();
        chk("bcy_ready_n2", {31'd0, br_ready}, 32'd1);
        push(K_DONE, 32'd1);
        issue(3'b111, 32'h600, 32'h0);
        chk("ill_done", {31'd0, br_done}, 32'd1);
        chk("ill_flag", {31'd0, br_illegal}, 32'd1);
        chk("ill_pc_held", redirect_pc, 32'h100);

        // Simultaneous flag write and branch acceptance
        set_flags(1'b0, 1'b0, 1'b0);
        wait_idle();
`ifdef FLAG_BYPASS_EN
        push(K_REDIR, 32'h80); push(K_FLUSH, 32'd2);
`else
        push(K_DONE, 32'd0);
`endif
        alu_zero = 1'b1; flag_we = 1'b1;
        br_op = 3'b010; br_target = 32'h80; br_valid = 1'b1;
        tick();
        flag_we = 1'b0; br_valid = 1'b0; alu_zero = 1'b0;
`ifdef FLAG_BYPASS_EN
        chk("byp_taken", {31'd0, redirect_valid}, 32'd1);
`else
        chk("nobyp_done", {31'd0, br_done}, 32'd1);
`endif
        chk("byp_flags", {29'd0, flags_q}, 32'h2);

        // Remaining opcodes
        push(K_DONE, 32'd0);
        issue(3'b011, 32'h700, 32'h0);
        set_flags(1'b0, 1'b0, 1'b1);
        push(K_REDIR, 32'h300); push(K_FLUSH, 32'd2);
        issue(3'b001, 32'h300, 32'h0);
        push(K_REDIR, 32'h304); push(K_FLUSH, 32'd2);
        issue(3'b110, 32'h304, 32'h0);
        push(K_DONE, 32'd0);
        issue(3'b010, 32'h308, 32'h0);

        // Reset during flush
        push(K_REDIR, 32'h200);
        issue(3'b000, 32'h200, 32'h0);
        tick();
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {27'd0, br_done, br_illegal, redirect_valid, link_we, flush}, 32'd0);
        chk("mid_rst_flags", {29'd0, flags_q}, 32'd0);
        chk("mid_rst_pc", redirect_pc, 32'd0);
        chk("mid_rst_link", link_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, br_ready}, 32'd1);
        chk("post_rst_flush", {31'd0, flush}, 32'd0);

        repeat (10) tick();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
